// File: rtl/pmod_lb_pkg.sv
// Shared types and defaults for the PMOD loopback driver/receiver pair.
// Holds the checker FSM states, the LED one-hot helper and common parameter defaults.
package pmod_lb_pkg;

  localparam int unsigned BUS_W              = 2;
  localparam int unsigned SETTLE_CYCLES_DEF  = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
  localparam int unsigned CNT_W_DEF          = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMPARE,
    REPORT
  } state_e;

  function automatic logic [3:0] led_onehot(input logic [BUS_W-1:0] v);
    led_onehot = 4'b0001 << v;
  endfunction

endpackage

// File: rtl/pmod_loopback_rx_if.sv
// Request/result handshake between a test sequencer (master) and the loopback checker (slave).
interface pmod_loopback_rx_if;

  logic                          sel;
  logic                          exp_valid;
  logic [pmod_lb_pkg::BUS_W-1:0] exp_data;
  logic                          busy;
  logic                          done;
  logic                          match;
  logic                          timeout;
  logic [pmod_lb_pkg::BUS_W-1:0] rx_data;

  modport master (
    output sel, exp_valid, exp_data,
    input  busy, done, match, timeout, rx_data
  );

  modport slave (
    input  sel, exp_valid, exp_data,
    output busy, done, match, timeout, rx_data
  );

endinterface

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer for the asynchronous PMOD pins.
module sync_2ff #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages shift on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pmod_loopback_rx.sv
// Receive/check end of the PMOD loopback: waits for a stable bus, compares, counts pass/fail.
// Optional feature macro: PMOD_LOOPBACK_RX_STICKY_ERR_EN adds err_sticky and an all-on LED error mode.
module pmod_loopback_rx
  import pmod_lb_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BUS_W-1:0]   pin_a,
  input  logic [BUS_W-1:0]   pin_b,
  pmod_loopback_rx_if.slave  req,
  input  logic               rd_en,
  output logic [3:0]         led,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt
`ifdef PMOD_LOOPBACK_RX_STICKY_ERR_EN
  ,
  output logic               err_sticky
`endif
);

  localparam int unsigned STAB_W = $clog2(SETTLE_CYCLES);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);

  logic [BUS_W-1:0] a_sync, b_sync, s;

  sync_2ff #(.W(BUS_W)) u_sync_a (.clk(clk), .rst(rst), .d(pin_a), .q(a_sync));
  sync_2ff #(.W(BUS_W)) u_sync_b (.clk(clk), .rst(rst), .d(pin_b), .q(b_sync));

  state_e            state_q,   state_d;
  logic              sel_q,     sel_d;
  logic [BUS_W-1:0]  exp_q,     exp_d;
  logic [BUS_W-1:0]  s_prev_q,  s_prev_d;
  logic [STAB_W-1:0] stab_q,    stab_d;
  logic [TO_W-1:0]   to_q,      to_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              match_q,   match_d;
  logic              timeout_q, timeout_d;
  logic [BUS_W-1:0]  rx_q,      rx_d;
  logic [CNT_W-1:0]  pass_q,    pass_d;
  logic [CNT_W-1:0]  fail_q,    fail_d;
  logic              err_q,     err_d;

  assign s = sel_q ? b_sync : a_sync;

  // NOTE: every *_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    exp_d     = exp_q;
    stab_d    = stab_q;
    to_d      = to_q;
    done_d    = 1'b0;
    match_d   = match_q;
    timeout_d = timeout_q;
    rx_d      = rx_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (req.exp_valid) begin
          exp_d   = req.exp_data;
          sel_d   = req.sel;
          stab_d  = '0;
          to_d    = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (stab_q == STAB_MAX) begin
          state_d = COMPARE;
        end else if (to_q == TO_MAX) begin
          timeout_d = 1'b1;
          match_d   = 1'b0;
          done_d    = 1'b1;
          state_d   = REPORT;
        end else begin
          stab_d = (s == s_prev_q) ? stab_q + 1'b1 : '0;
          to_d   = to_q + 1'b1;
        end
      end
      COMPARE: begin
        rx_d      = s;
        match_d   = (s == exp_q);
        timeout_d = 1'b0;
        done_d    = 1'b1;
        state_d   = REPORT;
      end
      REPORT: begin
        if (match_q) begin
          if (pass_q != '1) pass_d = pass_q + 1'b1;
        end else begin
          if (fail_q != '1) fail_d = fail_q + 1'b1;
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Track history on the port that will be selected next cycle, so a port switch
    // at acceptance does not cost a spurious stability reset.
    s_prev_d = sel_d ? b_sync : a_sync;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      exp_q     <= '0;
      s_prev_q  <= '0;
      stab_q    <= '0;
      to_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      rx_q      <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      exp_q     <= exp_d;
      s_prev_q  <= s_prev_d;
      stab_q    <= stab_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
      rx_q      <= rx_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
    end
  end

  assign req.busy    = busy_q;
  assign req.done    = done_q;
  assign req.match   = match_q;
  assign req.timeout = timeout_q;
  assign req.rx_data = rx_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;

`ifdef PMOD_LOOPBACK_RX_STICKY_ERR_EN
  assign err_sticky = err_q;
  assign led = !rd_en ? 4'b0000 : (err_q ? 4'b1111 : led_onehot(rx_q));
`else
  logic unused_err;
  assign unused_err = err_q;
  assign led = rd_en ? led_onehot(rx_q) : 4'b0000;
`endif

endmodule

// File: tb/tb_pmod_loopback_rx.sv
// Self-checking bench for pmod_loopback_rx: directed steps plus randomized checks against
// an outcome-level model (expected match, latency, saturating counters, sticky error).
module tb_pmod_loopback_rx;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 64;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pin_a, pin_b;
  logic       rd_en;
  logic [3:0] led;
  logic [7:0] pass_cnt, fail_cnt;
`ifdef PMOD_LOOPBACK_RX_STICKY_ERR_EN
  logic       err_sticky;
`endif

  pmod_loopback_rx_if bus ();

  pmod_loopback_rx #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_a     (pin_a),
    .pin_b     (pin_b),
    .req       (bus),
    .rd_en     (rd_en),
    .led       (led),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
`ifdef PMOD_LOOPBACK_RX_STICKY_ERR_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Outcome-level model state
  int         m_pass = 0;
  int         m_fail = 0;
  logic [1:0] m_rx   = 2'b00;
  bit         m_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic start_req(input logic s_sel, input logic [1:0] e);
    @(posedge clk);
    #1;
    bus.sel       = s_sel;
    bus.exp_data  = e;
    bus.exp_valid = 1'b1;
  endtask

  // Returns the cycle (1 = first cycle after acceptance edge) in which done is seen, 0 if never.
  task automatic wait_done(input bit toggle, input bit extra, output int lat);
    @(posedge clk);
    #1 bus.exp_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      if (toggle && (c % 4 == 0)) pin_a = ~pin_a;
      if (extra && c == 4) begin
        bus.exp_valid = 1'b1;
        bus.sel       = ~bus.sel;
        bus.exp_data  = ~bus.exp_data;
      end
      if (extra && c == 5) bus.exp_valid = 1'b0;
    end
  endtask

  task automatic full_check(input string tag, input logic s_sel, input logic [1:0] e,
                            input bit toggle, input bit extra, input bit exp_to);
    logic [1:0] s_val;
    logic       exp_m;
    logic [3:0] exp_led;
    int         lat;
    repeat (4) @(posedge clk);
    s_val = s_sel ? pin_b : pin_a;
    exp_m = !exp_to && (s_val == e);
    start_req(s_sel, e);
    wait_done(toggle, extra, lat);
    check({tag, ".latency"}, lat, exp_to ? TIMEOUT + 1 : SETTLE + 2);
    check({tag, ".busy_at_done"}, bus.busy, 1'b1);
    check({tag, ".match"}, bus.match, exp_m);
    check({tag, ".timeout"}, bus.timeout, exp_to);
    if (!exp_to) m_rx = s_val;
    check({tag, ".rx_data"}, bus.rx_data, m_rx);
    if (exp_m) m_pass = sat_inc(m_pass);
    else begin
      m_fail = sat_inc(m_fail);
      m_err  = 1'b1;
    end
    @(negedge clk);
    check({tag, ".done_one_cycle"}, bus.done, 1'b0);
    check({tag, ".busy_after"}, bus.busy, 1'b0);
    check({tag, ".pass_cnt"}, pass_cnt, m_pass);
    check({tag, ".fail_cnt"}, fail_cnt, m_fail);
    exp_led = 4'(1 << m_rx);
`ifdef PMOD_LOOPBACK_RX_STICKY_ERR_EN
    if (m_err) exp_led = 4'b1111;
    check({tag, ".err_sticky"}, err_sticky, m_err);
`endif
    rd_en = 1'b1;
    #1 check({tag, ".led_on"}, led, exp_led);
    rd_en = 1'b0;
    #1 check({tag, ".led_off"}, led, 4'b0000);
  endtask

  initial begin
    int n_done;
    rst           = 1'b1;
    pin_a         = 2'b00;
    pin_b         = 2'b00;
    rd_en         = 1'b1;
    bus.sel       = 1'b0;
    bus.exp_valid = 1'b0;
    bus.exp_data  = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", bus.busy, 1'b0);
    check("rst.done", bus.done, 1'b0);
    check("rst.match", bus.match, 1'b0);
    check("rst.timeout", bus.timeout, 1'b0);
    check("rst.rx_data", bus.rx_data, 2'b00);
    check("rst.pass_cnt", pass_cnt, 8'd0);
    check("rst.fail_cnt", fail_cnt, 8'd0);
    rd_en = 1'b0;
    #1 check("rst.led", led, 4'b0000);
    rst = 1'b0;

    // Stable port A, expected equal
    pin_a = 2'b10;
    full_check("t1_pass", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);

    // Port B, mismatch
    pin_b = 2'b01;
    full_check("t2_mismatch", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);

    // Port A toggling every 4 cycles never settles
    full_check("t3_timeout", 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

    // Second request during a check must be dropped and not perturb sel/exp
    pin_a = 2'b11;
    pin_b = 2'b00;
    full_check("t4_ignored", 1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    check("t4.extra_done", n_done, 0);

    // Randomized stable-bus checks
    for (int i = 0; i < 20; i++) begin
      logic       rs;
      logic [1:0] re;
      pin_a = 2'($urandom_range(0, 3));
      pin_b = 2'($urandom_range(0, 3));
      rs    = 1'($urandom_range(0, 1));
      re    = ($urandom_range(0, 1) == 1) ? (rs ? pin_b : pin_a) : 2'($urandom_range(0, 3));
      full_check("rand", rs, re, 1'b0, 1'b0, 1'b0);
    end

    // Drive pass_cnt to saturation, then one more pass
    pin_a = 2'b01;
    while (m_pass < CNT_MAX) full_check("sat_fill", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    full_check("sat_hold", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    check("sat.pass_cnt", pass_cnt, 8'd255);

    // Mismatch followed by match leaves the error indication up
    full_check("sticky_mis", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    full_check("sticky_ok", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);

    // Reset during SETTLE
    repeat (4) @(posedge clk);
    start_req(1'b0, 2'b01);
    @(posedge clk);
    #1 bus.exp_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid.busy_before", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid.busy", bus.busy, 1'b0);
    check("rst_mid.pass_cnt", pass_cnt, 8'd0);
    check("rst_mid.fail_cnt", fail_cnt, 8'd0);
    check("rst_mid.done", bus.done, 1'b0);
    m_pass = 0;
    m_fail = 0;
    m_rx   = 2'b00;
    m_err  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    check("rst_mid.no_done", n_done, 0);
    full_check("post_rst", 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pmod_loopback_rx.md
# pmod_loopback_rx

Receive and check end of the PMOD loopback link. Samples the 2-bit looped-back bus from either PMOD port and synchronizes it into the clock domain. Waits for the bus to be stable, then compares the value against the expected value and accumulates pass/fail counts. Sits beside the tristate driver block on the Genesys 2 test design; its LED and status outputs feed the board LEDs and the ILA.

## Interface
- SETTLE_CYCLES, 16: consecutive identical synchronized samples required before a compare (≥2).
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting for stability before declaring a timeout (> SETTLE_CYCLES).
- CNT_W, 8: width of the pass and fail counters.
- clk  in  1  system clock (clk_out1 of the clock wizard).
- rst  in  1  reset, asynchronous, active-high.
- pin_a  in  2  looped-back bus from port A (selected when sel=0).
- pin_b  in  2  looped-back bus from port B (selected when sel=1).
- sel  in  1  port select; sampled only when a request is accepted.
- exp_valid  in  1  request strobe; exp_data is valid in the same cycle.
- exp_data  in  2  expected loopback value.
- busy  out  1  high from request acceptance until done.
- done  out  1  one-cycle pulse at the end of a check.
- match  out  1  result of the last check (1 = equal); held until the next done.
- timeout  out  1  last check ended by timeout; held until the next done.
- rx_data  out  2  last captured bus value.
- rd_en  in  1  LED display enable.
- led  out  4  one-hot of rx_data when rd_en=1, else 0.
- pass_cnt  out  CNT_W  count of matching checks, saturating.
- fail_cnt  out  CNT_W  count of mismatched and timed-out checks, saturating.

## Operation
- Input path: pin_a and pin_b each pass through a 2-FF synchronizer. The selected port's synchronized value is the sample s.
- FSM states: IDLE, SETTLE, COMPARE, REPORT.
- IDLE: busy=0. When exp_valid=1, latch exp_data and sel, clear the stability and timeout counters, and go to SETTLE. When exp_valid=0, stay in IDLE.
- SETTLE: each cycle, if s equals s from the previous cycle, the stability counter increments; otherwise it clears to 0.
  - When the stability counter reaches SETTLE_CYCLES-1, go to COMPARE.
  - Otherwise, when the timeout counter reaches TIMEOUT_CYCLES-1, go to REPORT with timeout=1 and match=0.
  - If both conditions hold in the same cycle, stability wins.
- COMPARE: capture rx_data=s and set match=(s==exp_latched), timeout=0. Go to REPORT.
- REPORT: done=1 for exactly one cycle. Increment pass_cnt if match=1, else increment fail_cnt. Both counters saturate at all-ones. Go to IDLE.
- exp_valid while busy=1 is ignored; it is not queued. Changes on sel or exp_data during a check are ignored.
- led: rd_en=1 gives led[rx_data]=1, all other bits 0. rd_en=0 gives led=0. This output is combinational from registered rx_data and rd_en.

## Timing
- Reset values: busy=0, done=0, match=0, timeout=0, rx_data=0, led=0, pass_cnt=0, fail_cnt=0, FSM in IDLE.
- Reset asserted mid-check returns the block to IDLE immediately. No done pulse is produced and the counters are cleared.
- The synchronizer adds 2 cycles from a pin change to s.
- With a bus that is already stable, exp_valid at cycle 0 gives:
  - SETTLE in cycles 1 … SETTLE_CYCLES,
  - COMPARE at cycle SETTLE_CYCLES+1,
  - done at cycle SETTLE_CYCLES+2.
  - Latency is SETTLE_CYCLES+2.
- Worst-case latency on timeout is TIMEOUT_CYCLES+1.
- A new request can be accepted in the cycle after done.

## Configuration
- PMOD_LOOPBACK_RX_STICKY_ERR_EN defined:
  - Adds output err_sticky. It is set on any done with match=0 and cleared only by rst.
  - While err_sticky=1 and rd_en=1, led is forced to 4'b1111.
- Undefined: no err_sticky port; led follows rx_data only.

## Structure
- Shared package pmod_lb_pkg holds:
  - the FSM state enum (IDLE, SETTLE, COMPARE, REPORT),
  - a function returning the 4-bit one-hot LED pattern for a 2-bit value,
  - default parameter constants shared with the driver block.
- One sub-module, sync_2ff: a parameterized-width 2-flop synchronizer with async active-high reset. It is instantiated once per port.

## Test plan
- pin_a=2'b10 held, sel=0, exp_data=2'b10, exp_valid pulse → done at +18 cycles with SETTLE_CYCLES=16; match=1, rx_data=2, pass_cnt=1; with rd_en=1, led=4'b0100.
- pin_b=2'b01, sel=1, exp_data=2'b11 → match=0, fail_cnt=1, rx_data=1, timeout=0.
- pin_a toggling every 4 cycles with TIMEOUT_CYCLES=64 → done at +65 cycles with timeout=1, match=0, fail_cnt incremented.
- Second exp_valid at +5 cycles during a check → ignored; only one done is produced, and exp_latched and sel are unchanged.
- 255 passing checks with CNT_W=8, then one more pass → pass_cnt stays at 255.
- rst asserted during SETTLE → busy=0 and counters=0 in the same cycle, no done pulse. With PMOD_LOOPBACK_RX_STICKY_ERR_EN defined: one mismatch followed by one match leaves err_sticky=1 and led=4'b1111 with rd_en=1.
